nf10_axis_stream_monitor: RTL and testbench

- Passive, synthesizable AXI4-Stream sink monitor; successor to the simulation-only recorder tap on output-queue ports.
- Parametrised in data and tuser width. Counts packets and bytes, tracks the in-packet state, and flags protocol violations with sticky error bits.
- Drives tready itself, so it can terminate any m_axis port on hardware or in simulation.

---
 rtl/nf10_axis_mon_pkg.sv | 22 ++
 rtl/nf10_axis_strb_check.sv | 30 +++
 rtl/nf10_axis_stream_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_nf10_axis_stream_monitor.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_axis_mon_pkg.sv
// Shared types and constants for the AXI4-Stream sink monitor.
package nf10_axis_mon_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    localparam int ERR_VALID_DROP   = 0;
    localparam int ERR_STALL_CHANGE = 1;
    localparam int ERR_STRB         = 2;
    localparam int ERR_OVERSIZE     = 3;

    // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/nf10_axis_strb_check.sv
// Strobe analysis: byte count, last-beat legality (nonzero, contiguous from
// bit 0) and the all-ones condition required on non-last beats.
module nf10_axis_strb_check #(
    parameter int C_STRB_WIDTH = 32,
    parameter int C_CNT_WIDTH  = $clog2(C_STRB_WIDTH + 1)
) (
    input  logic [C_STRB_WIDTH-1:0] strb,
    output logic [C_CNT_WIDTH-1:0]  count,
    output logic                    legal_last,
    output logic                    all_ones
);

    logic [C_STRB_WIDTH-1:0] strb_inc;

    // Population count of the strobe lanes
    always_comb begin
        count = '0;
        for (int i = 0; i < C_STRB_WIDTH; i++) begin
            count = count + C_CNT_WIDTH'(strb[i]);
        end
    end

    // A mask of the form 0..01..1 has no bit in common with itself plus one
    always_comb begin
        strb_inc   = strb + {{(C_STRB_WIDTH-1){1'b0}}, 1'b1};
        legal_last = (strb != '0) && ((strb & strb_inc) == '0);
        all_ones   = &strb;
    end

endmodule

// File: rtl/nf10_axis_stream_monitor.sv
// Passive AXI4-Stream sink monitor: counts packets and bytes, tracks packet
// framing and latches protocol violations in sticky error bits.
// Build option NF10_AXIS_MON_BACKPRESSURE_EN: tready is driven from an LFSR
// to inject roughly 25% stall cycles; otherwise tready stays high.
module nf10_axis_stream_monitor
    import nf10_axis_mon_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_COUNT_WIDTH        = 32,
    parameter int C_PKT_LEN_WIDTH      = 16,
    parameter int C_MAX_PKT_BYTES      = 10240,
    parameter int C_ACTIVITY_HOLD      = 255
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_COUNT_WIDTH-1:0]          pkt_count,
    output logic [C_COUNT_WIDTH-1:0]          byte_count,
    output logic [C_PKT_LEN_WIDTH-1:0]        last_pkt_bytes,
    output logic                              in_packet,
    output logic                              activity,
    output logic [3:0]                        err
);

    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(STRB_W + 1);
    localparam int ACT_W  = ($clog2(C_ACTIVITY_HOLD + 1) > 8) ? $clog2(C_ACTIVITY_HOLD + 1) : 8;
    localparam logic [ACT_W-1:0]         ACT_RELOAD = ACT_W'(C_ACTIVITY_HOLD);
    localparam logic [C_PKT_LEN_WIDTH:0] MAX_PKT    = (C_PKT_LEN_WIDTH + 1)'(C_MAX_PKT_BYTES);

    state_t                         state;
    state_t                         next_state;
    logic                           in_packet_d;
    logic                           beat_ok;
    logic [CNT_W-1:0]               beat_bytes;
    logic                           legal_last;
    logic                           all_ones;
    logic [C_PKT_LEN_WIDTH-1:0]     pkt_acc;
    logic [C_PKT_LEN_WIDTH:0]       acc_sum;
    logic [C_PKT_LEN_WIDTH-1:0]     acc_sat;
    logic [C_COUNT_WIDTH:0]         byte_sum;
    logic [C_COUNT_WIDTH-1:0]       byte_sat;
    logic [C_COUNT_WIDTH-1:0]       pkt_next;
    logic                           over_flagged;
    logic                           oversize_hit;
    logic                           stalled;
    logic [C_S_AXIS_DATA_WIDTH-1:0] cap_tdata;
    logic [STRB_W-1:0]              cap_tstrb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] cap_tuser;
    logic                           cap_tlast;
    logic                           fields_changed;
    logic [3:0]                     err_set;
    logic [ACT_W-1:0]               act_cnt;

    nf10_axis_strb_check #(
        .C_STRB_WIDTH (STRB_W),
        .C_CNT_WIDTH  (CNT_W)
    ) u_strb_check (
        .strb       (s_axis_tstrb),
        .count      (beat_bytes),
        .legal_last (legal_last),
        .all_ones   (all_ones)
    );

`ifdef NF10_AXIS_MON_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Free-running LFSR used as the stall pattern source
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr_feedback(lfsr)};
    end

    // Ready low whenever the two LSBs are zero
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) s_axis_tready <= 1'b0;
        else       s_axis_tready <= (lfsr[1:0] != 2'b00);
    end
`else
    // Ready rises on the first edge after reset and stays high
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) s_axis_tready <= 1'b0;
        else       s_axis_tready <= 1'b1;
    end
`endif

    // Handshake, accumulator arithmetic and saturation
    always_comb begin
        beat_ok      = s_axis_tvalid & s_axis_tready;
        acc_sum      = {1'b0, pkt_acc} + (C_PKT_LEN_WIDTH + 1)'(beat_bytes);
        acc_sat      = acc_sum[C_PKT_LEN_WIDTH] ? '1 : acc_sum[C_PKT_LEN_WIDTH-1:0];
        byte_sum     = {1'b0, byte_count} + (C_COUNT_WIDTH + 1)'(beat_bytes);
        byte_sat     = byte_sum[C_COUNT_WIDTH] ? '1 : byte_sum[C_COUNT_WIDTH-1:0];
        pkt_next     = (pkt_count == '1) ? pkt_count : pkt_count + 1'b1;
        oversize_hit = beat_ok & ~over_flagged & (acc_sum > MAX_PKT);
    end

    // FSM state register
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next state: any accepted beat decides framing from tlast
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (beat_ok && !s_axis_tlast) next_state = IN_PKT;
            IN_PKT:  if (beat_ok && s_axis_tlast)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM output: in_packet tracks the state register cycle for cycle
    always_comb begin
        in_packet_d = (next_state == IN_PKT);
    end

    // Registered in_packet output
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) in_packet <= 1'b0;
        else       in_packet <= in_packet_d;
    end

    // Per-packet accumulator and the once-per-packet oversize latch; clear does not touch these
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            pkt_acc      <= '0;
            over_flagged <= 1'b0;
        end else if (beat_ok) begin
            pkt_acc      <= s_axis_tlast ? '0 : acc_sat;
            over_flagged <= s_axis_tlast ? 1'b0 : (over_flagged | oversize_hit);
        end
    end

    // Global counters; clear has priority over a coincident beat
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            pkt_count      <= '0;
            byte_count     <= '0;
            last_pkt_bytes <= '0;
        end else if (clear) begin
            pkt_count      <= '0;
            byte_count     <= '0;
            last_pkt_bytes <= '0;
        end else if (beat_ok) begin
            byte_count <= byte_sat;
            if (s_axis_tlast) begin
                pkt_count      <= pkt_next;
                last_pkt_bytes <= acc_sat;
            end
        end
    end

    // Capture the offered beat whenever it is held off by tready
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            stalled   <= 1'b0;
            cap_tdata <= '0;
            cap_tstrb <= '0;
            cap_tuser <= '0;
            cap_tlast <= 1'b0;
        end else begin
            stalled <= s_axis_tvalid & ~s_axis_tready;
            if (s_axis_tvalid && !s_axis_tready) begin
                cap_tdata <= s_axis_tdata;
                cap_tstrb <= s_axis_tstrb;
                cap_tuser <= s_axis_tuser;
                cap_tlast <= s_axis_tlast;
            end
        end
    end

    // Violation detection for this cycle
    always_comb begin
        fields_changed = (cap_tdata != s_axis_tdata) || (cap_tstrb != s_axis_tstrb) ||
                         (cap_tuser != s_axis_tuser) || (cap_tlast != s_axis_tlast);
        err_set                   = '0;
        err_set[ERR_VALID_DROP]   = stalled & ~s_axis_tvalid;
        err_set[ERR_STALL_CHANGE] = stalled & s_axis_tvalid & fields_changed;
        err_set[ERR_STRB]         = beat_ok & (s_axis_tlast ? ~legal_last : ~all_ones);
        err_set[ERR_OVERSIZE]     = oversize_hit;
    end

    // Sticky error bits; clear wins over a coincident violation
    always_ff @(posedge aclk or posedge reset) begin
        if (reset)      err <= '0;
        else if (clear) err <= '0;
        else            err <= err | err_set;
    end

    // Activity stretcher: reload on every accepted beat, count down to zero
    always_ff @(posedge aclk or posedge reset) begin
        if (reset)              act_cnt <= '0;
        else if (beat_ok)       act_cnt <= ACT_RELOAD;
        else if (act_cnt != '0) act_cnt <= act_cnt - 1'b1;
    end

    assign activity = (act_cnt != '0);

endmodule

// File: tb/tb_nf10_axis_stream_monitor.sv
// Self-checking bench for nf10_axis_stream_monitor at default parameters.
module tb_nf10_axis_stream_monitor;

    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    logic           aclk = 1'b0;
    logic           reset;
    logic           clear;
    logic [DW-1:0]  s_axis_tdata;
    logic [SW-1:0]  s_axis_tstrb;
    logic [UW-1:0]  s_axis_tuser;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic           s_axis_tlast;
    logic [31:0]    pkt_count;
    logic [31:0]    byte_count;
    logic [15:0]    last_pkt_bytes;
    logic           in_packet;
    logic           activity;
    logic [3:0]     err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int unsigned m_pkt_count;
    int unsigned m_byte_count;
    int unsigned m_last;
    int unsigned m_acc;
    logic [3:0]  m_err;
    bit          m_in_pkt;
    bit          m_over;

    nf10_axis_stream_monitor dut (
        .aclk           (aclk),
        .reset          (reset),
        .clear          (clear),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .pkt_count      (pkt_count),
        .byte_count     (byte_count),
        .last_pkt_bytes (last_pkt_bytes),
        .in_packet      (in_packet),
        .activity       (activity),
        .err            (err)
    );

    always #5 aclk = ~aclk;

    function automatic void model_reset();
        m_pkt_count = 0; m_byte_count = 0; m_last = 0; m_acc = 0;
        m_err = 4'b0; m_in_pkt = 1'b0; m_over = 1'b0;
    endfunction

    function automatic void model_clear();
        m_pkt_count = 0; m_byte_count = 0; m_last = 0; m_err = 4'b0;
    endfunction

    // One accepted beat, derived from the packet rules directly
    function automatic void model_beat(input logic [31:0] strb, input bit last, input bit clr);
        int          n;
        logic [63:0] mask;
        bit          bad;
        n    = $countones(strb);
        mask = (64'd1 << n) - 64'd1;
        bad  = last ? (n == 0 || strb != mask[31:0]) : (strb != 32'hFFFF_FFFF);
        m_acc        += n;
        m_byte_count += n;
        if (bad) m_err[2] = 1'b1;
        if (m_acc > 10240 && !m_over) begin
            m_err[3] = 1'b1;
            m_over   = 1'b1;
        end
        if (last) begin
            m_last = m_acc;
            m_pkt_count++;
            m_acc    = 0;
            m_over   = 1'b0;
            m_in_pkt = 1'b0;
        end else begin
            m_in_pkt = 1'b1;
        end
        if (clr) model_clear();
    endfunction

    function automatic logic [84:0] dut_vec();
        return {pkt_count, byte_count, last_pkt_bytes, err, in_packet};
    endfunction

    function automatic logic [84:0] model_vec();
        return {m_pkt_count, m_byte_count, m_last[15:0], m_err, m_in_pkt};
    endfunction

    function automatic string show(input logic [84:0] v);
        return $sformatf("pkt=%0d bytes=%0d last=%0d err=%b in_pkt=%b",
                         v[84:53], v[52:21], v[20:5], v[4:1], v[0]);
    endfunction

    task automatic drive_random_payload();
        for (int i = 0; i < DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
        for (int i = 0; i < UW / 32; i++) s_axis_tuser[i*32 +: 32] = $urandom;
    endtask

    // Offer one beat from a negedge; returns #1 after the accepting edge
    task automatic send_beat(input logic [31:0] strb, input bit last, input bit clr);
        int waitc;
        waitc = 0;
        @(negedge aclk);
        drive_random_payload();
        s_axis_tstrb  = strb;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        clear         = clr;
        while (!s_axis_tready && waitc < 100) begin
            @(negedge aclk);
            waitc++;
        end
        if (waitc >= 100) begin
            tests++; fails++;
            $display("FAIL send_beat: tready stayed 0 for %0d cycles, required 1", waitc);
        end else begin
            @(posedge aclk);
            model_beat(strb, last, clr);
        end
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge aclk);
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
        model_clear();
    endtask

    task automatic do_reset();
        @(negedge aclk);
        reset = 1'b1; s_axis_tvalid = 1'b0; clear = 1'b0;
        @(negedge aclk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        model_reset();
        repeat (2) @(negedge aclk);
        tests++;
        if ({dut_vec(), s_axis_tready, activity} !== 87'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %s tready=%b act=%b, required all 0",
                     show(dut_vec()), s_axis_tready, activity);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_before_edge: got %b required 0", s_axis_tready);
        end
        @(posedge aclk);
        #1;
        tests++;
        if (s_axis_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_after_edge: got %b required 1", s_axis_tready);
        end
    endtask

    task automatic test_three_beat();
        logic [31:0] strbs [3];
        int          inpkt_hi;
        strbs[0] = 32'hFFFF_FFFF; strbs[1] = 32'hFFFF_FFFF; strbs[2] = 32'h0000_FFFF;
        inpkt_hi = 0;
        for (int b = 0; b < 3; b++) begin
            send_beat(strbs[b], (b == 2), 1'b0);
            if (in_packet === 1'b1) inpkt_hi++;
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++;
                $display("FAIL three_beat_%0d: got %s required %s", b, show(dut_vec()), show(model_vec()));
            end
        end
        tests++;
        if (pkt_count !== 32'd1 || byte_count !== 32'd80 || last_pkt_bytes !== 16'd80 ||
            err !== 4'b0 || inpkt_hi != 2) begin
            fails++;
            $display("FAIL three_beat_totals: got %s in_pkt_cycles=%0d, required pkt=1 bytes=80 last=80 err=0 cycles=2",
                     show(dut_vec()), inpkt_hi);
        end
    endtask

    task automatic test_single_beat();
        do_clear();
        send_beat(32'h0000_000F, 1'b1, 1'b0);
        tests++;
        if (pkt_count !== 32'd1 || last_pkt_bytes !== 16'd4 || in_packet !== 1'b0 ||
            dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL single_beat: got %s required pkt=1 last=4 in_pkt=0", show(dut_vec()));
        end
    endtask

    task automatic test_strb_error();
        send_beat(32'h0000_00F0, 1'b1, 1'b0);
        tests++;
        if (err !== 4'b0100 || dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL strb_error: got %s required err=0100", show(dut_vec()));
        end
        do_clear();
        tests++;
        if (err !== 4'b0 || pkt_count !== 32'd0 || dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL strb_error_clear: got %s required err=0 pkt=0", show(dut_vec()));
        end
    endtask

    task automatic test_clear_with_beat();
        send_beat(32'hFFFF_FFFF, 1'b0, 1'b1);
        tests++;
        if (byte_count !== 32'd0 || in_packet !== 1'b1 || dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL clear_with_beat: got %s required bytes=0 in_pkt=1", show(dut_vec()));
        end
        send_beat(32'h0000_FFFF, 1'b1, 1'b0);
        tests++;
        if (last_pkt_bytes !== 16'd48 || byte_count !== 32'd16 || pkt_count !== 32'd1 ||
            dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL clear_with_beat_tail: got %s required pkt=1 bytes=16 last=48", show(dut_vec()));
        end
    endtask

    // tready is low in the first cycle after reset, which makes a stall available in any build
    task automatic test_stall_drop();
        @(negedge aclk);
        reset = 1'b1;
        drive_random_payload();
        s_axis_tstrb = 32'hFFFF_FFFF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
        model_reset();
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        m_err[0] = 1'b1;
        tests++;
        if (dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL stall_valid_drop: got %s required %s", show(dut_vec()), show(model_vec()));
        end
    endtask

    task automatic test_stall_change();
        @(negedge aclk);
        reset = 1'b1;
        drive_random_payload();
        s_axis_tstrb = 32'hFFFF_FFFF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
        model_reset();
        @(posedge aclk);
        #1;
        s_axis_tdata = ~s_axis_tdata;
        @(posedge aclk);
        m_err[1] = 1'b1;
        model_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        tests++;
        if (dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL stall_payload_change: got %s required %s", show(dut_vec()), show(model_vec()));
        end
    endtask

`ifdef NF10_AXIS_MON_BACKPRESSURE_EN
    task automatic wait_ready_low(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge aclk);
            if (s_axis_tready === 1'b0) found = 1'b1;
        end
    endtask

    task automatic test_backpressure();
        bit found;
        wait_ready_low(found);
        drive_random_payload();
        s_axis_tstrb = 32'hFFFF_FFFF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        s_axis_tdata = ~s_axis_tdata;
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        tests++;
        if (!found || err[1] !== 1'b1) begin
            fails++;
            $display("FAIL bp_payload_change: got err=%b ready_low_seen=%0d, required err[1]=1", err, found);
        end
        do_clear();
        wait_ready_low(found);
        s_axis_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        tests++;
        if (!found || err[0] !== 1'b1) begin
            fails++;
            $display("FAIL bp_valid_drop: got err=%b ready_low_seen=%0d, required err[0]=1", err, found);
        end
        do_reset();
    endtask
`endif

    task automatic test_oversize();
        do_clear();
        for (int b = 0; b < 328; b++) send_beat(32'hFFFF_FFFF, (b == 327), 1'b0);
        tests++;
        if (last_pkt_bytes !== 16'd10496 || err !== 4'b1000 || dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL oversize: got %s required last=10496 err=1000", show(dut_vec()));
        end
    endtask

    task automatic test_activity();
        send_beat(32'h0000_0001, 1'b1, 1'b0);
        repeat (254) @(posedge aclk);
        #1;
        tests++;
        if (activity !== 1'b1) begin
            fails++;
            $display("FAIL activity_hold: got %b after 254 idle cycles, required 1", activity);
        end
        @(posedge aclk);
        #1;
        tests++;
        if (activity !== 1'b0) begin
            fails++;
            $display("FAIL activity_expire: got %b after 255 idle cycles, required 0", activity);
        end
    endtask

    task automatic test_random();
        int          nb;
        bit          last;
        logic [31:0] strb;
        logic [63:0] mask;
        for (int p = 0; p < 40; p++) begin
            if (p % 8 == 0) do_clear();
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                last = (b == nb - 1);
                repeat ($urandom_range(0, 2)) @(negedge aclk);
                if (last) begin
                    if ($urandom_range(0, 9) < 8) begin
                        mask = (64'd1 << $urandom_range(1, 32)) - 64'd1;
                        strb = mask[31:0];
                    end else begin
                        strb = $urandom;
                    end
                end else begin
                    strb = ($urandom_range(0, 9) < 9) ? 32'hFFFF_FFFF : $urandom;
                end
                send_beat(strb, last, ($urandom_range(0, 29) == 0));
                tests++;
                if (dut_vec() !== model_vec()) begin
                    fails++;
                    $display("FAIL random_p%0d_b%0d: got %s required %s", p, b, show(dut_vec()), show(model_vec()));
                end
            end
        end
    endtask

    task automatic test_reset_midpacket();
        send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge aclk);
        reset = 1'b1;
        #1;
        tests++;
        if ({dut_vec(), s_axis_tready, activity} !== 87'd0) begin
            fails++;
            $display("FAIL midpkt_reset_outputs: got %s tready=%b act=%b, required all 0",
                     show(dut_vec()), s_axis_tready, activity);
        end
        @(negedge aclk);
        reset = 1'b0;
        model_reset();
        send_beat(32'h0000_FFFF, 1'b1, 1'b0);
        tests++;
        if (pkt_count !== 32'd1 || last_pkt_bytes !== 16'd16 || dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL midpkt_after_reset: got %s required pkt=1 last=16", show(dut_vec()));
        end
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_single_beat();
        test_strb_error();
        test_clear_with_beat();
        test_stall_drop();
        test_stall_change();
`ifdef NF10_AXIS_MON_BACKPRESSURE_EN
        test_backpressure();
`endif
        test_oversize();
        test_activity();
        test_random();
        test_reset_midpacket();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
